// File: rtl/fft_sm_pkg.sv
// Shared definitions for the FFT state-machine sample loader:
// default dimensions, sequencer state encoding and the bit-reverse helper.
package fft_sm_pkg;

  localparam int unsigned DefLog2N = 8;
  localparam int unsigned DefN     = 1 << DefLog2N;
  localparam int unsigned DefAw    = 10;
  localparam int unsigned DefDw    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain
  } state_e;

  // Reverse the low log2n bits of k; bits above log2n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned log2n);
    logic [31:0] n;
    logic [31:0] t;
    n = '0;
    t = k;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < log2n) begin
        n = {n[30:0], t[0]};
        t = t >> 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fft_sm_loader_if.sv
// Valid/ready stream from the loader to the FFT working-memory writer.
// Each beat carries a memory slot address and a complex sample.
interface fft_sm_loader_if #(
  parameter int unsigned AddrW = fft_sm_pkg::DefLog2N,
  parameter int unsigned DataW = fft_sm_pkg::DefDw
);
  logic             valid;
  logic             ready;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] re;
  logic [DataW-1:0] im;

  modport master (output valid, output addr, output re, output im, input ready);
  modport slave  (input valid, input addr, input re, input im, output ready);
endinterface

// File: rtl/fft_sm_bitrev.sv
// Combinational slot-to-sample index reverser: n = bitrev(k) over LOG2N bits,
// zero-extended to AW. Shared with the output-unload sequencer.
module fft_sm_bitrev
  import fft_sm_pkg::*;
#(
  parameter int unsigned LOG2N = DefLog2N,
  parameter int unsigned AW    = DefAw
) (
  input  logic [LOG2N-1:0] k_i,
  output logic [AW-1:0]    n_o
);

  // Pure wiring permutation; no logic depth.
  always_comb begin
    n_o = AW'(bitrev(32'(k_i), LOG2N));
  end

endmodule

// File: rtl/fft_sm_loader.sv
// FFT initial-sample loader. Sweeps working-memory slots k = 0..N-1, drives the
// sample LUT at n = bitrev(k) and streams (k, re, 0) through a single-stage output
// register, so the working memory ends up in bit-reversed order.
// Build option: FFT_SM_LOADER_PRESCALE_EN divides each sample by N (arithmetic
// shift right by LOG2N) for butterfly headroom; timing is unchanged.
module fft_sm_loader
  import fft_sm_pkg::*;
#(
  parameter int unsigned LOG2N = DefLog2N,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [AW-1:0]   lut_n_o,
  input  logic [DW-1:0]   lut_x_re_i,
  fft_sm_loader_if.master out_if
);

  localparam logic [LOG2N-1:0] KLast = '1;

  state_e           state_q, state_d;
  logic [LOG2N-1:0] k_q, k_d;
  logic             valid_q, valid_d;
  logic [LOG2N-1:0] addr_q, addr_d;
  logic [DW-1:0]    re_q, re_d;
  logic             done_q, done_d;

  logic [AW-1:0]    n_rev;
  logic [DW-1:0]    sample;
  logic             free;
  logic             hs;

  fft_sm_bitrev #(
    .LOG2N(LOG2N),
    .AW   (AW)
  ) u_bitrev (
    .k_i(k_q),
    .n_o(n_rev)
  );

`ifdef FFT_SM_LOADER_PRESCALE_EN
  logic signed [DW-1:0] lut_s;
  assign lut_s  = $signed(lut_x_re_i);
  assign sample = lut_s >>> LOG2N;
`else
  assign sample = lut_x_re_i;
`endif

  assign free = !valid_q || out_if.ready;
  assign hs   = valid_q && out_if.ready;

  // Next-state: sweep control, output-register capture and done pulse.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    re_d    = re_q;
    done_d  = 1'b0;

    // A handshake empties the output register unless a capture refills it below.
    if (hs) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // done_q high means we only just left DRAIN; that start is not honoured.
        if (start_i && !done_q) begin
          state_d = StLoad;
          k_d     = '0;
        end
      end
      StLoad: begin
        if (free) begin
          valid_d = 1'b1;
          addr_d  = k_q;
          re_d    = sample;
          if (k_q == KLast) begin
            state_d = StDrain;
          end else begin
            k_d = k_q + LOG2N'(1);
          end
        end
      end
      StDrain: begin
        if (hs) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; asynchronous reset abandons any partial load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      re_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      done_q  <= done_d;
    end
  end

  // Outputs: LUT address is forced to zero while idle.
  always_comb begin
    busy_o     = (state_q != StIdle);
    done_o     = done_q;
    lut_n_o    = busy_o ? n_rev : '0;
    out_if.valid = valid_q;
    out_if.addr  = addr_q;
    out_if.re    = re_q;
    out_if.im    = '0;
  end

endmodule

// File: tb/tb_fft_sm_loader.sv
// Bench for fft_sm_loader: a LOG2N=8 instance driven through full loads with
// steady and pseudo-random backpressure, restart/reset corner cases, and a
// LOG2N=1 instance for the two-beat case.
module tb_fft_sm_loader;

  logic        clk;
  logic        rst;
  logic        start, busy, done;
  logic [9:0]  lut_n;
  logic [31:0] lut_x_re;
  logic        start1, busy1, done1;
  logic [9:0]  lut_n1;
  logic [31:0] lut_x_re1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] got_re [256];
  logic [9:0]  got_n  [256];

  typedef struct {
    int          k;
    logic [9:0]  n;
    logic [31:0] re;
  } vec_t;
  vec_t vecs [4];

  fft_sm_loader_if #(.AddrW(8), .DataW(32)) out8 ();
  fft_sm_loader_if #(.AddrW(1), .DataW(32)) out1 ();

  fft_sm_loader #(.LOG2N(8), .AW(10), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .lut_n_o   (lut_n),
    .lut_x_re_i(lut_x_re),
    .out_if    (out8)
  );

  fft_sm_loader #(.LOG2N(1), .AW(10), .DW(32)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start1),
    .busy_o    (busy1),
    .done_o    (done1),
    .lut_n_o   (lut_n1),
    .lut_x_re_i(lut_x_re1),
    .out_if    (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample table: four hand-fixed entries, linear filler elsewhere.
  function automatic logic [31:0] lut_fn(input logic [9:0] n);
    case (n)
      10'd0:   return 32'd0;
      10'd128: return 32'hFFFF_FFFE;
      10'd64:  return 32'hFFFF_FFED;
      10'd255: return 32'd6;
      default: return 32'(n) * 32'd7 - 32'd500;
    endcase
  endfunction

  function automatic int brev(input int k, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic logic [31:0] exp_re(input int n, input int sh);
    logic [31:0] v;
    v = lut_fn(10'(n));
`ifdef FFT_SM_LOADER_PRESCALE_EN
    return 32'($signed(v) >>> sh);
`else
    if (sh < 0) v = 32'd0;
    return v;
`endif
  endfunction

  assign lut_x_re  = lut_fn(lut_n);
  assign lut_x_re1 = lut_fn(lut_n1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Full load on the 8-bit instance; call at a negedge with the DUT idle.
  task automatic run_stream(input bit rand_rdy, input bit repulse, input bit chk_lat);
    int cap_cnt, hs_idx, done_cnt, first_hs, last_hs, done_at, first_v;
    bit prev_stall, prev_cap, cap, ds_pending;
    logic [7:0]  prev_addr;
    logic [31:0] prev_re;
    cap_cnt = 0; hs_idx = 0; done_cnt = 0;
    first_hs = -1; last_hs = -1; done_at = -1; first_v = -1;
    prev_stall = 0; prev_cap = 0; ds_pending = 0;
    prev_addr = '0; prev_re = '0;
    out8.ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start = 1'b0;
      out8.ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (ds_pending) begin
        chk("start_on_done_ignored_busy", 32'(busy), 32'd0);
        chk("start_on_done_ignored_valid", 32'(out8.valid), 32'd0);
        ds_pending = 0;
      end
      if (chk_lat && cyc == 0) begin
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_no_valid_yet", 32'(out8.valid), 32'd0);
      end
      if (out8.valid && first_v < 0) first_v = cyc;
      if (prev_stall) begin
        chk("stall_valid", 32'(out8.valid), 32'd1);
        chk("stall_addr", 32'(out8.addr), 32'(prev_addr));
        chk("stall_re", out8.re, prev_re);
      end
      if (prev_cap) begin
        chk("beat_addr", 32'(out8.addr), 32'(cap_cnt - 1));
        chk("beat_re", out8.re, exp_re(brev(cap_cnt - 1, 8), 8));
        chk("beat_im", out8.im, 32'd0);
        got_re[cap_cnt - 1] = out8.re;
      end
      cap = 0;
      if (busy && cap_cnt < 256 && (!out8.valid || out8.ready)) begin
        chk("lut_n", 32'(lut_n), 32'(brev(cap_cnt, 8)));
        got_n[cap_cnt] = lut_n;
        cap_cnt++;
        cap = 1;
      end
      if (out8.valid && out8.ready) begin
        chk("hs_order", 32'(out8.addr), 32'(hs_idx));
        if (hs_idx == 0) first_hs = cyc;
        hs_idx++;
        if (hs_idx == 256) last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
        if (repulse) begin
          start = 1'b1;
          ds_pending = 1;
        end
      end
      if (repulse && prev_cap && out8.addr == 8'd37) start = 1'b1;
      prev_stall = out8.valid && !out8.ready;
      prev_addr  = out8.addr;
      prev_re    = out8.re;
      prev_cap   = cap;
      @(negedge clk);
      if (done_at >= 0 && cyc > done_at + 2) break;
    end
    start = 1'b0;
    chk("beats_delivered", 32'(hs_idx), 32'd256);
    chk("captures", 32'(cap_cnt), 32'd256);
    chk("single_done", 32'(done_cnt), 32'd1);
    chk("done_after_last_hs", 32'(done_at), 32'(last_hs + 1));
    chk("idle_after_load", 32'(busy), 32'd0);
    if (chk_lat) begin
      chk("first_valid_latency", 32'(first_v), 32'd1);
      chk("back_to_back_span", 32'(last_hs - first_hs), 32'd255);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    out8.ready = 1'b1;
    out1.ready = 1'b1;
    vecs[0] = '{k: 0,   n: 10'd0,   re: 32'd0};
    vecs[3] = '{k: 255, n: 10'd255, re: 32'd6};
`ifdef FFT_SM_LOADER_PRESCALE_EN
    vecs[1] = '{k: 1,   n: 10'd128, re: 32'hFFFF_FFFF};
    vecs[2] = '{k: 2,   n: 10'd64,  re: 32'hFFFF_FFFF};
    vecs[3].re = 32'd0;
`else
    vecs[1] = '{k: 1,   n: 10'd128, re: 32'hFFFF_FFFE};
    vecs[2] = '{k: 2,   n: 10'd64,  re: 32'hFFFF_FFED};
`endif

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out8.valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(out8.addr), 32'd0);
    chk("rst_re", out8.re, 32'd0);
    chk("rst_im", out8.im, 32'd0);
    chk("rst_lut_n", 32'(lut_n), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Steady ready, then the hand-computed table.
    run_stream(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tbl_lut_n_k%0d", vecs[i].k), 32'(got_n[vecs[i].k]), 32'(vecs[i].n));
      chk($sformatf("tbl_re_k%0d", vecs[i].k), got_re[vecs[i].k], vecs[i].re);
    end

    // Backpressure, then backpressure with start re-pulsed at k=37 and on done.
    run_stream(1'b1, 1'b0, 1'b0);
    run_stream(1'b1, 1'b1, 1'b0);

    // Asynchronous reset while beat 100 is stalled.
    out8.ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (out8.valid && out8.addr == 8'd100) begin
        out8.ready = 1'b0;
        found = 1;
        break;
      end
    end
    chk("reach_k100", 32'(found), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out8.valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_addr", 32'(out8.addr), 32'd0);
    chk("async_rst_lut_n", 32'(lut_n), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_done_after_rst", 32'(done), 32'd0);
    run_stream(1'b0, 1'b0, 1'b1);

    // LOG2N=1 instance: two beats, identity reversal.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("l1_busy", 32'(busy1), 32'd1);
    chk("l1_lut_n_k0", 32'(lut_n1), 32'd0);
    chk("l1_no_valid_yet", 32'(out1.valid), 32'd0);
    @(negedge clk);
    chk("l1_beat0_valid", 32'(out1.valid), 32'd1);
    chk("l1_beat0_addr", 32'(out1.addr), 32'd0);
    chk("l1_beat0_re", out1.re, exp_re(0, 1));
    chk("l1_lut_n_k1", 32'(lut_n1), 32'd1);
    @(negedge clk);
    chk("l1_beat1_valid", 32'(out1.valid), 32'd1);
    chk("l1_beat1_addr", 32'(out1.addr), 32'd1);
    chk("l1_beat1_re", out1.re, exp_re(1, 1));
    chk("l1_no_early_done", 32'(done1), 32'd0);
    @(negedge clk);
    chk("l1_done", 32'(done1), 32'd1);
    chk("l1_valid_cleared", 32'(out1.valid), 32'd0);
    chk("l1_idle", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("l1_done_one_cycle", 32'(done1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
